// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - key event bundle from the keypad scanner to the operand-entry FSMs
interface keypad_scanner_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       is_digit;
    logic       is_op;
    logic       is_equal;
    logic       is_clear;
    logic       key_held;

    modport master (
        output key_valid, key_code, is_digit, is_op, is_equal, is_clear, key_held
    );

    modport slave (
        input key_valid, key_code, is_digit, is_op, is_equal, is_clear, key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with press/release debounce
module keypad_scanner #(
    parameter int CLK_DIV  = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        row_n,
    output logic [3:0]        col_n,
    keypad_scanner_if.master  key_if
);
    localparam int              TW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [3:0]      DEB_N     = 4'(DEBOUNCE);

    typedef enum logic [2:0] {SCAN, DEB_PRESS, EMIT, WAIT_REL, DEB_REL} state_t;

    logic [3:0]    row_meta_q, rows_s_q;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    state_t        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;
    logic [3:0]    flags_q, flags_d;      // {digit, op, equal, clear}
    logic          key_held_q, key_held_d;

    logic          tick, any_low, do_emit, do_release;
    logic [1:0]    win_row;
    logic [3:0]    emit_code;

    // Row index to code for the currently driven column.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;
            default: key_map = 4'hD;
        endcase
    endfunction

    // Lowest pressed row index wins when several rows are low.
    always_comb begin
        any_low = ~&rows_s_q;
        if (!rows_s_q[0])      win_row = 2'd0;
        else if (!rows_s_q[1]) win_row = 2'd1;
        else if (!rows_s_q[2]) win_row = 2'd2;
        else                   win_row = 2'd3;
        emit_code = key_map(win_row, col_q);
    end

    // Free-running tick divider plus the scan/debounce next-state logic.
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        flags_d     = 4'b0000;
        key_held_d  = key_held_q;
        do_emit     = 1'b0;
        do_release  = 1'b0;
        case (state_q)
            SCAN: if (tick) begin
                if (any_low) begin
                    row_d = win_row;
                    cnt_d = 4'd1;
                    if (DEB_N == 4'd1) do_emit = 1'b1;
                    else               state_d = DEB_PRESS;
                end else begin
                    col_d = col_q + 2'd1;
                end
            end
            DEB_PRESS: if (tick) begin
                if (any_low && (win_row == row_q)) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == DEB_N) do_emit = 1'b1;
                end else begin
                    state_d = SCAN;
                    cnt_d   = 4'd0;
                end
            end
            EMIT: begin
                state_d = WAIT_REL;
                cnt_d   = 4'd0;
            end
            WAIT_REL: if (tick && !any_low) begin
                cnt_d = 4'd1;
                if (DEB_N == 4'd1) do_release = 1'b1;
                else               state_d = DEB_REL;
            end
            DEB_REL: if (tick) begin
                if (!any_low) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == DEB_N) do_release = 1'b1;
                end else begin
                    state_d = WAIT_REL;
                    cnt_d   = 4'd0;
                end
            end
            default: state_d = SCAN;
        endcase
        if (do_emit) begin
            state_d     = EMIT;
            key_valid_d = 1'b1;
            key_code_d  = emit_code;
            flags_d     = {emit_code <= 4'h9,
                           (emit_code >= 4'hA) && (emit_code <= 4'hD),
                           emit_code == 4'hF,
                           emit_code == 4'hE};
            key_held_d  = 1'b1;
        end
        if (do_release) begin
            state_d    = SCAN;
            cnt_d      = 4'd0;
            key_held_d = 1'b0;
            col_d      = col_q + 2'd1;
        end
    end

    // State registers; row_n is double-synchronised before any decision uses it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta_q  <= 4'hF;
            rows_s_q    <= 4'hF;
            tick_cnt_q  <= '0;
            state_q     <= SCAN;
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            cnt_q       <= 4'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            flags_q     <= 4'b0000;
            key_held_q  <= 1'b0;
        end else begin
            row_meta_q  <= row_n;
            rows_s_q    <= row_meta_q;
            tick_cnt_q  <= tick_cnt_d;
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            flags_q     <= flags_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col_n            = ~(4'b0001 << col_q);
    assign key_if.key_valid = key_valid_q;
    assign key_if.key_code  = key_code_q;
    assign key_if.is_digit  = flags_q[3];
    assign key_if.is_op     = flags_q[2];
    assign key_if.is_equal  = flags_q[1];
    assign key_if.is_clear  = flags_q[0];
    assign key_if.key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] keys, keys1;         // key index = row*4 + col
    logic [3:0]  row_n, row_n1, col_n, col_n1;
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_q0[$];           // {digit, op, equal, clear, code}
    logic [7:0]  exp_q1[$];
    logic        prev_v0 = 1'b0, prev_v1 = 1'b0;

    keypad_scanner_if kif();
    keypad_scanner_if kif1();

    keypad_scanner #(.CLK_DIV(4), .DEBOUNCE(3)) dut (
        .clk(clk), .reset(reset), .row_n(row_n), .col_n(col_n), .key_if(kif));
    keypad_scanner #(.CLK_DIV(4), .DEBOUNCE(1)) dut1 (
        .clk(clk), .reset(reset), .row_n(row_n1), .col_n(col_n1), .key_if(kif1));

    always #5 clk = ~clk;

    // Passive keypad: a pressed key shorts its row to the driven column.
    always_comb begin
        row_n  = 4'hF;
        row_n1 = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c]  && !col_n[c])  row_n[r]  = 1'b0;
                if (keys1[r*4+c] && !col_n1[c]) row_n1[r] = 1'b0;
            end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (4 * n) @(negedge clk);
    endtask

    // Wait for the column drive of the chosen DUT to switch to column c.
    task automatic wait_col(input int which, input int c);
        logic [3:0] tgt, cur, prev;
        logic       found;
        tgt   = ~(4'b0001 << c);
        prev  = which ? col_n1 : col_n;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            cur = which ? col_n1 : col_n;
            if (cur == tgt && prev != tgt) found = 1'b1;
            prev = cur;
        end
        if (!found) check("wait_col_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard monitor for the DEBOUNCE=3 instance.
    always @(negedge clk) begin
        if (!reset) prev_v0 <= 1'b0;
        else begin
            if (kif.key_valid) begin
                check("pulse_width0", prev_v0, 0);
                if (exp_q0.size() == 0) check("unexpected_event0", 1, 0);
                else begin
                    logic [7:0] e;
                    e = exp_q0.pop_front();
                    check("key_code0", kif.key_code, e[3:0]);
                    check("flags0", {kif.is_digit, kif.is_op, kif.is_equal, kif.is_clear}, e[7:4]);
                end
            end else begin
                check("flags_idle0", {kif.is_digit, kif.is_op, kif.is_equal, kif.is_clear}, 0);
            end
            prev_v0 <= kif.key_valid;
        end
    end

    // Scoreboard monitor for the DEBOUNCE=1 instance.
    always @(negedge clk) begin
        if (!reset) prev_v1 <= 1'b0;
        else begin
            if (kif1.key_valid) begin
                check("pulse_width1", prev_v1, 0);
                if (exp_q1.size() == 0) check("unexpected_event1", 1, 0);
                else begin
                    logic [7:0] e;
                    e = exp_q1.pop_front();
                    check("key_code1", kif1.key_code, e[3:0]);
                    check("flags1", {kif1.is_digit, kif1.is_op, kif1.is_equal, kif1.is_clear}, e[7:4]);
                end
            end else begin
                check("flags_idle1", {kif1.is_digit, kif1.is_op, kif1.is_equal, kif1.is_clear}, 0);
            end
            prev_v1 <= kif1.key_valid;
        end
    end

    initial begin
        logic [3:0] exp_col;
        reset = 1'b0;
        keys  = '0;
        keys1 = '0;
        repeat (3) @(negedge clk);
        check("rst_col", col_n, 4'b1110);
        check("rst_valid", kif.key_valid, 0);
        check("rst_code", kif.key_code, 0);
        check("rst_held", kif.key_held, 0);
        check("rst_col1", col_n1, 4'b1110);
        reset = 1'b1;

        // Idle scan: column advances every 4 cycles and wraps.
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            exp_col = ~(4'b0001 << (k % 4));
            check("idle_col", col_n, exp_col);
            repeat (4) @(negedge clk);
        end

        // Digit 5, held 20 ticks; pulse 2 ticks + 1 cycle after detection.
        wait_col(0, 1);
        keys[5] = 1'b1;
        exp_q0.push_back(8'h85);
        repeat (11) @(negedge clk);
        check("five_early", kif.key_valid, 0);
        @(negedge clk);
        check("five_latency", kif.key_valid, 1);
        check("five_held", kif.key_held, 1);
        ticks(17);
        keys[5] = 1'b0;
        check("five_code_hold", kif.key_code, 4'h5);
        ticks(2);
        check("five_held_rel2", kif.key_held, 1);
        ticks(1);
        check("five_released", kif.key_held, 0);
        check("five_col_adv", col_n, 4'b1011);

        // Bounce on key A, then clean press.
        wait_col(0, 3);
        keys[3] = 1'b1;
        ticks(2);
        keys[3] = 1'b0;
        ticks(1);
        check("bounce_col_hold", col_n, 4'b0111);
        keys[3] = 1'b1;
        exp_q0.push_back(8'h4A);
        ticks(5);
        keys[3] = 1'b0;
        ticks(4);

        // Equal then clear.
        wait_col(0, 2);
        keys[14] = 1'b1;
        exp_q0.push_back(8'h2F);
        ticks(4);
        keys[14] = 1'b0;
        ticks(4);
        wait_col(0, 0);
        keys[12] = 1'b1;
        exp_q0.push_back(8'h1E);
        ticks(4);
        keys[12] = 1'b0;
        ticks(4);

        // Rollover: hold 1, add 9 and 4, release 1; still one event.
        wait_col(0, 0);
        keys[0] = 1'b1;
        exp_q0.push_back(8'h81);
        ticks(4);
        keys[10] = 1'b1;
        keys[4]  = 1'b1;
        ticks(2);
        keys[0] = 1'b0;
        ticks(4);
        check("rollover_held", kif.key_held, 1);
        keys[4]  = 1'b0;
        keys[10] = 1'b0;
        ticks(4);
        check("rollover_released", kif.key_held, 0);
        ticks(8);

        // DEBOUNCE=1: single-tick press of 9 emits on the cycle after the tick.
        wait_col(1, 2);
        keys1[10] = 1'b1;
        exp_q1.push_back(8'h89);
        repeat (3) @(negedge clk);
        check("deb1_early", kif1.key_valid, 0);
        @(negedge clk);
        check("deb1_valid", kif1.key_valid, 1);
        keys1[10] = 1'b0;
        ticks(3);
        check("deb1_released", kif1.key_held, 0);

        // Asynchronous reset while a key is held mid-scan.
        wait_col(0, 1);
        keys[5] = 1'b1;
        exp_q0.push_back(8'h85);
        ticks(4);
        check("pre_reset_held", kif.key_held, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_rst_col", col_n, 4'b1110);
        check("async_rst_valid", kif.key_valid, 0);
        check("async_rst_held", kif.key_held, 0);
        check("async_rst_code", kif.key_code, 0);
        keys = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        ticks(4);

        check("queue0_drained", exp_q0.size(), 0);
        check("queue1_drained", exp_q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
